// File: rtl/prio_enc_scan.sv
// ============================================================================
// Module      : prio_enc_scan
// Description : Registered N-bit priority encoder with stability filter,
//               max-hold capture mode, change pulse and a two-digit
//               multiplexed seven-segment hex display driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc_scan #(
    parameter int N        = 16,
    parameter int STABLE   = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [N-1:0]           sw,
    output logic                   valid,
    output logic [$clog2(N)-1:0]   idx,
    output logic                   changed,
    output logic [7:0]             seg,
    output logic [1:0]             an
);

    localparam int IW  = $clog2(N);
    localparam int SCW = $clog2(SCAN_DIV);
    // The upper digit only carries information when the index exceeds 4 bits.
    localparam bit TWO_DIGITS = (IW > 4);

    localparam logic [1:0]     MODE_FILT = 2'b01;
    localparam logic [1:0]     MODE_HOLD = 2'b10;
    localparam logic [7:0]     CNT_LAST  = 8'(STABLE - 1);
    localparam logic [7:0]     CNT_SAT   = 8'(STABLE);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    // Returns {hit, index of highest set bit}; all zeros for an empty vector.
    function automatic logic [IW:0] enc(input logic [N-1:0] v);
        logic [IW:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    logic [N-1:0]   sw_prev;
    logic [N-1:0]   filt;
    logic [N-1:0]   filt_next;
    logic [7:0]     cnt;
    logic [SCW-1:0] scan;
    logic           dsel;
    logic           dsel_next;
    logic [IW:0]    e_sw;
    logic [IW:0]    e_filt;
    logic           valid_next;
    logic [IW-1:0]  idx_next;
    logic [7:0]     idx_pad;
    logic [3:0]     nibble;

    // Next filtered value; encoding it directly lets filtered outputs update
    // on the same edge the filter accepts a new value.
    always_comb begin
        filt_next = filt;
        if (!en) begin
            filt_next = '0;
        end else if ((sw == sw_prev) && (cnt == CNT_LAST)) begin
            filt_next = sw;
        end
    end

    // Mode-dependent next value of {valid, idx}.
    always_comb begin
        e_sw       = enc(sw);
        e_filt     = enc(filt_next);
        valid_next = valid;
        idx_next   = idx;
        if (!en) begin
            valid_next = 1'b0;
            idx_next   = '0;
        end else begin
            case (mode)
                MODE_FILT: begin
                    valid_next = e_filt[IW];
                    idx_next   = e_filt[IW-1:0];
                end
                MODE_HOLD: begin
                    if (e_sw[IW] && (!valid || (e_sw[IW-1:0] > idx))) begin
                        valid_next = 1'b1;
                        idx_next   = e_sw[IW-1:0];
                    end
                end
                default: begin
                    valid_next = e_sw[IW];
                    idx_next   = e_sw[IW-1:0];
                end
            endcase
        end
    end

    // Stability filter and encoder output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_prev <= '0;
            cnt     <= '0;
            filt    <= '0;
            valid   <= 1'b0;
            idx     <= '0;
            changed <= 1'b0;
        end else begin
            sw_prev <= sw;
            if (!en || (sw != sw_prev)) begin
                cnt <= '0;
            end else if (cnt < CNT_SAT) begin
                cnt <= cnt + 8'd1;
            end
            filt    <= filt_next;
            valid   <= valid_next;
            idx     <= idx_next;
            changed <= ({valid_next, idx_next} != {valid, idx});
        end
    end

    always_comb begin
        dsel_next = dsel;
        if (TWO_DIGITS && (scan == SCAN_LAST)) dsel_next = ~dsel;
    end

    // Digit scan timer; anodes follow the digit select so they stay aligned
    // with the combinational segment pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan <= '0;
            dsel <= 1'b0;
            an   <= 2'b10;
        end else begin
            scan <= (scan == SCAN_LAST) ? '0 : scan + SCW'(1);
            dsel <= dsel_next;
            an   <= dsel_next ? 2'b01 : 2'b10;
        end
    end

    // Hex glyph lookup for the selected nibble, dash when nothing is valid.
    always_comb begin
        idx_pad = 8'(idx);
        nibble  = dsel ? idx_pad[7:4] : idx_pad[3:0];
        seg     = 8'hBF;
        if (valid) begin
            case (nibble)
                4'h0: seg = 8'hC0;
                4'h1: seg = 8'hF9;
                4'h2: seg = 8'hA4;
                4'h3: seg = 8'hB0;
                4'h4: seg = 8'h99;
                4'h5: seg = 8'h92;
                4'h6: seg = 8'h82;
                4'h7: seg = 8'hF8;
                4'h8: seg = 8'h80;
                4'h9: seg = 8'h90;
                4'hA: seg = 8'h88;
                4'hB: seg = 8'h83;
                4'hC: seg = 8'hC6;
                4'hD: seg = 8'hA1;
                4'hE: seg = 8'h86;
                default: seg = 8'h8E;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_scan.sv
// ============================================================================
// Module      : tb_prio_enc_scan
// Description : Directed self-checking bench for prio_enc_scan (N=16 and
//               N=256 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_enc_scan;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [1:0]  mode;
    logic [15:0] sw;
    logic        valid;
    logic [3:0]  idx;
    logic        changed;
    logic [7:0]  seg;
    logic [1:0]  an;

    logic         rst2_n, en2;
    logic [1:0]   mode2;
    logic [255:0] sw2;
    logic         valid2;
    logic [7:0]   idx2;
    logic         changed2;
    logic [7:0]   seg2;
    logic [1:0]   an2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prio_enc_scan #(.N(16), .STABLE(4), .SCAN_DIV(1024)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sw(sw),
        .valid(valid), .idx(idx), .changed(changed), .seg(seg), .an(an)
    );

    prio_enc_scan #(.N(256), .STABLE(4), .SCAN_DIV(8)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2), .sw(sw2),
        .valid(valid2), .idx(idx2), .changed(changed2), .seg(seg2), .an(an2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] ix, input logic ch);
        check({tag, "_valid"},   32'(valid),   32'(v));
        check({tag, "_idx"},     32'(idx),     32'(ix));
        check({tag, "_changed"}, 32'(changed), 32'(ch));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'b00; sw = 16'hFFFF;
        rst2_n = 1'b0; en2 = 1'b1; mode2 = 2'b00; sw2 = '0;
        #2;
        // Reset overrides enable and a full request vector.
        step(3);
        chk_out("reset", 1'b0, 4'd0, 1'b0);
        check("reset_an",  32'(an),  32'h2);
        check("reset_seg", 32'(seg), 32'hBF);

        // Direct mode.
        rst_n = 1'b1;
        sw = 16'h0001; step(); chk_out("dir_0001", 1'b1, 4'd0, 1'b1);
        check("dir_seg0", 32'(seg), 32'hC0);
        sw = 16'h0090; step(); chk_out("dir_0090", 1'b1, 4'd7, 1'b1);
        check("dir_seg7", 32'(seg), 32'hF8);
        sw = 16'h8000; step(); chk_out("dir_8000", 1'b1, 4'd15, 1'b1);
        check("dir_segF", 32'(seg), 32'h8E);
        sw = 16'h0000; step(); chk_out("dir_0000", 1'b0, 4'd0, 1'b1);
        check("dir_dash", 32'(seg), 32'hBF);
        step(); chk_out("dir_hold0", 1'b0, 4'd0, 1'b0);

        // Mode 11 behaves like direct.
        mode = 2'b11; sw = 16'h0300; step(); chk_out("m11_0300", 1'b1, 4'd9, 1'b1);
        sw = 16'h0000; step(); chk_out("m11_0000", 1'b0, 4'd0, 1'b1);

        // Filtered: a 3-edge glitch never reaches the outputs.
        mode = 2'b01; step(2);
        sw = 16'h0400;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out("filt_glitch", 1'b0, 4'd0, 1'b0);
        end
        sw = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out("filt_after", 1'b0, 4'd0, 1'b0);
        end
        // Steady value appears exactly 4 edges after the first edge.
        sw = 16'h0400;
        for (int i = 0; i < 4; i++) begin
            step(); chk_out("filt_wait", 1'b0, 4'd0, 1'b0);
        end
        step(); chk_out("filt_load", 1'b1, 4'd10, 1'b1);
        step(); chk_out("filt_steady", 1'b1, 4'd10, 1'b0);

        // Max-hold, starting from a cleared state.
        en = 1'b0; step(); chk_out("en_off", 1'b0, 4'd0, 1'b1);
        en = 1'b1; mode = 2'b10;
        sw = 16'h0020; step(); chk_out("hold_0020", 1'b1, 4'd5, 1'b1);
        sw = 16'h0004; step(); chk_out("hold_0004", 1'b1, 4'd5, 1'b0);
        sw = 16'h0000; step(); chk_out("hold_0000", 1'b1, 4'd5, 1'b0);
        sw = 16'h1000; step(); chk_out("hold_1000", 1'b1, 4'd12, 1'b1);
        sw = 16'h0010; step(); chk_out("hold_0010", 1'b1, 4'd12, 1'b0);
        en = 1'b0; step(); chk_out("hold_clear", 1'b0, 4'd0, 1'b1);

        // Enable drop mid-filter restarts the stability window.
        mode = 2'b01; sw = 16'h0000; step(2);
        en = 1'b1; step(6);
        sw = 16'h0008; step(3);          // count now at 2
        en = 1'b0; step();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out("en_restart_wait", 1'b0, 4'd0, 1'b0);
        end
        step(); chk_out("en_restart_load", 1'b1, 4'd3, 1'b1);

        // Reset pulse mid-filter: history is cleared as well.
        rst_n = 1'b0; step();
        rst_n = 1'b1; sw = 16'h0000; step(6);
        sw = 16'h0008; step(3);
        rst_n = 1'b0; step();
        chk_out("rst_mid", 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); chk_out("rst_restart_wait", 1'b0, 4'd0, 1'b0);
        end
        step(); chk_out("rst_restart_load", 1'b1, 4'd3, 1'b1);
        check("n16_an_fixed", 32'(an), 32'h2);

        // Display scanning on the 256-wide instance.
        rst2_n = 1'b0; step();
        check("d2_reset_seg", 32'(seg2), 32'hBF);
        check("d2_reset_an",  32'(an2),  32'h2);
        rst2_n = 1'b1;
        sw2 = '0;
        sw2[8'hA7] = 1'b1;
        step();
        check("d2_idx",   32'(idx2),   32'hA7);
        check("d2_valid", 32'(valid2), 32'h1);
        check("d2_an_lo",  32'(an2),  32'h2);
        check("d2_seg_lo", 32'(seg2), 32'hF8);
        step(6);                         // edge 7: still low digit
        check("d2_an_lo7",  32'(an2),  32'h2);
        check("d2_seg_lo7", 32'(seg2), 32'hF8);
        step();                          // edge 8: switch to high digit
        check("d2_an_hi",  32'(an2),  32'h1);
        check("d2_seg_hi", 32'(seg2), 32'h88);
        step(7);                         // edge 15
        check("d2_an_hi15",  32'(an2),  32'h1);
        check("d2_seg_hi15", 32'(seg2), 32'h88);
        step();                          // edge 16: back to low digit
        check("d2_an_lo16",  32'(an2),  32'h2);
        check("d2_seg_lo16", 32'(seg2), 32'hF8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
